// File: rtl/symcounter_pkg.sv
// Shared types and default timing constants for the symbol-counting game.
// Holds the round/level sequencer state enum and a state-class helper.
package symcounter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELIM,
    S_ANSWER,
    S_POST,
    S_LEVEL,
    S_DONE
  } seq_state_t;

  localparam int DEF_TICK_DIV         = 50000;
  localparam int DEF_PRELIM_TICKS     = 20;
  localparam int DEF_ANSWER_TICKS     = 50;
  localparam int DEF_POST_TICKS       = 10;
  localparam int DEF_ROUNDS_PER_LEVEL = 4;
  localparam int DEF_MAX_LEVEL        = 8;

  // IDLE and DONE are the only untimed, non-busy states.
  function automatic logic is_rest(seq_state_t s);
    return (s == S_IDLE) || (s == S_DONE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into one-cycle ticks every TICK_DIV cycles.
// Ports: clk, reset (async high), clear (restart count), tick (out).
module tick_prescaler
  import symcounter_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/period_sequencer.sv
// Round/level FSM: PRELIM -> ANSWER -> POST per round, LEVEL between levels.
// Ports: clk, reset, start, answerDone in; period levels, level, round,
// ticksLeft, busy, gameOver out (all registered).
module period_sequencer
  import symcounter_pkg::*;
#(
  parameter int TICK_DIV         = DEF_TICK_DIV,
  parameter int PRELIM_TICKS     = DEF_PRELIM_TICKS,
  parameter int ANSWER_TICKS     = DEF_ANSWER_TICKS,
  parameter int POST_TICKS       = DEF_POST_TICKS,
  parameter int ROUNDS_PER_LEVEL = DEF_ROUNDS_PER_LEVEL,
  parameter int MAX_LEVEL        = DEF_MAX_LEVEL,
  parameter int TICK_W           = 8,
  parameter int LEVEL_W          = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               answerDone,
  output logic               prelimPeriod,
  output logic               answerPeriod,
  output logic               postPeriod,
  output logic               levelChng,
  output logic [LEVEL_W-1:0] level,
  output logic [LEVEL_W-1:0] round,
  output logic [TICK_W-1:0]  ticksLeft,
  output logic               busy,
  output logic               gameOver
);

  seq_state_t state_q, state_d;
  logic [TICK_W-1:0]  ticks_q, ticks_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LEVEL_W-1:0] round_q, round_d;
  logic prelim_q, prelim_d;
  logic answer_q, answer_d;
  logic post_q, post_d;
  logic lvlchg_q, lvlchg_d;
  logic busy_q, busy_d;
  logic over_q, over_d;

  logic tick;
  logic enter;
  logic expire;

  // Prescaler restarts on every state entry and idles in IDLE/DONE,
  // so a timed state lasts exactly N*TICK_DIV cycles.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .reset(reset),
    .clear(enter || is_rest(state_q)),
    .tick (tick)
  );

  assign expire = tick && (ticks_q == TICK_W'(1));

  always_comb begin
    state_d = state_q;
    ticks_d = ticks_q;
    level_d = level_q;
    round_d = round_q;
    enter   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PRELIM;
          ticks_d = TICK_W'(PRELIM_TICKS);
          level_d = '0;
          round_d = '0;
          enter   = 1'b1;
        end
      end
      S_PRELIM: begin
        if (expire) begin
          state_d = S_ANSWER;
          ticks_d = TICK_W'(ANSWER_TICKS);
          enter   = 1'b1;
        end else if (tick) begin
          ticks_d = ticks_q - TICK_W'(1);
        end
      end
      S_ANSWER: begin
        // Early submit and expiry merge into one POST entry.
        if (answerDone || expire) begin
          state_d = S_POST;
          ticks_d = TICK_W'(POST_TICKS);
          enter   = 1'b1;
        end else if (tick) begin
          ticks_d = ticks_q - TICK_W'(1);
        end
      end
      S_POST: begin
        if (expire) begin
          enter = 1'b1;
          if (round_q < LEVEL_W'(ROUNDS_PER_LEVEL - 1)) begin
            state_d = S_PRELIM;
            ticks_d = TICK_W'(PRELIM_TICKS);
            round_d = round_q + LEVEL_W'(1);
          end else begin
            state_d = S_LEVEL;
            ticks_d = TICK_W'(1);
            round_d = '0;
          end
        end else if (tick) begin
          ticks_d = ticks_q - TICK_W'(1);
        end
      end
      S_LEVEL: begin
        if (expire) begin
          enter = 1'b1;
          if (level_q == LEVEL_W'(MAX_LEVEL - 1)) begin
            state_d = S_DONE;
            ticks_d = '0;
          end else begin
            state_d = S_PRELIM;
            ticks_d = TICK_W'(PRELIM_TICKS);
            level_d = level_q + LEVEL_W'(1);
          end
        end else if (tick) begin
          ticks_d = ticks_q - TICK_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ticks_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they rise on the
  // transition edge itself.
  always_comb begin
    prelim_d = (state_d == S_PRELIM);
    answer_d = (state_d == S_ANSWER);
    post_d   = (state_d == S_POST);
    lvlchg_d = (state_d == S_LEVEL);
    busy_d   = !is_rest(state_d);
    over_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ticks_q  <= '0;
      level_q  <= '0;
      round_q  <= '0;
      prelim_q <= 1'b0;
      answer_q <= 1'b0;
      post_q   <= 1'b0;
      lvlchg_q <= 1'b0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ticks_q  <= ticks_d;
      level_q  <= level_d;
      round_q  <= round_d;
      prelim_q <= prelim_d;
      answer_q <= answer_d;
      post_q   <= post_d;
      lvlchg_q <= lvlchg_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  assign prelimPeriod = prelim_q;
  assign answerPeriod = answer_q;
  assign postPeriod   = post_q;
  assign levelChng    = lvlchg_q;
  assign level        = level_q;
  assign round        = round_q;
  assign ticksLeft    = ticks_q;
  assign busy         = busy_q;
  assign gameOver     = over_q;

endmodule

// File: tb/tb_period_sequencer.sv
// Bench for period_sequencer: vector table, corner sequences, random run
// against a cycle-countdown reference model.
module tb_period_sequencer;

  localparam int TD = 4;
  localparam int PT = 2;
  localparam int AT = 3;
  localparam int OT = 1;
  localparam int RPL = 2;
  localparam int ML = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic answerDone = 1'b0;
  logic prelimPeriod, answerPeriod, postPeriod, levelChng;
  logic [3:0] level, round;
  logic [7:0] ticksLeft;
  logic busy, gameOver;

  int total = 0;
  int bad = 0;

  period_sequencer #(
    .TICK_DIV(TD), .PRELIM_TICKS(PT), .ANSWER_TICKS(AT),
    .POST_TICKS(OT), .ROUNDS_PER_LEVEL(RPL), .MAX_LEVEL(ML),
    .TICK_W(8), .LEVEL_W(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .answerDone(answerDone),
    .prelimPeriod(prelimPeriod), .answerPeriod(answerPeriod),
    .postPeriod(postPeriod), .levelChng(levelChng),
    .level(level), .round(round), .ticksLeft(ticksLeft),
    .busy(busy), .gameOver(gameOver)
  );

  always #5 clk = ~clk;

  // Model: phase 0 idle,1 prelim,2 answer,3 post,4 level,5 done.
  // Time is tracked in raw clk cycles left; ticks are derived.
  int m_ph = 0;
  int m_cyc = 0;
  int m_lvl = 0;
  int m_rnd = 0;

  task automatic m_enter(input int ph, input int n);
    m_ph = ph;
    m_cyc = n * TD;
  endtask

  task automatic m_reset();
    m_ph = 0; m_cyc = 0; m_lvl = 0; m_rnd = 0;
  endtask

  task automatic m_step(input bit st, input bit ad);
    case (m_ph)
      0, 5: if (st) begin
        m_lvl = 0; m_rnd = 0; m_enter(1, PT);
      end
      1: begin
        m_cyc--;
        if (m_cyc == 0) m_enter(2, AT);
      end
      2: begin
        m_cyc--;
        if (ad || m_cyc == 0) m_enter(3, OT);
      end
      3: begin
        m_cyc--;
        if (m_cyc == 0) begin
          if (m_rnd < RPL - 1) begin
            m_rnd++; m_enter(1, PT);
          end else begin
            m_rnd = 0; m_enter(4, 1);
          end
        end
      end
      4: begin
        m_cyc--;
        if (m_cyc == 0) begin
          if (m_lvl == ML - 1) begin
            m_ph = 5; m_cyc = 0;
          end else begin
            m_lvl++; m_enter(1, PT);
          end
        end
      end
      default: m_reset();
    endcase
  endtask

  function automatic logic [21:0] m_vec();
    logic [7:0] tl;
    tl = 8'((m_cyc + TD - 1) / TD);
    return {m_ph == 1, m_ph == 2, m_ph == 3, m_ph == 4,
            (m_ph >= 1 && m_ph <= 4), m_ph == 5,
            4'(m_lvl), 4'(m_rnd), tl};
  endfunction

  function automatic logic [21:0] d_vec();
    return {prelimPeriod, answerPeriod, postPeriod, levelChng,
            busy, gameOver, level, round, ticksLeft};
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string nm);
    cmp(nm, 32'(d_vec()), 32'(m_vec()));
  endtask

  task automatic step(input string nm);
    @(posedge clk);
    if (reset) m_reset();
    else m_step(start, answerDone);
    #1;
    check_model(nm);
    start = 1'b0;
    answerDone = 1'b0;
  endtask

  typedef struct {
    bit st;
    bit ad;
    int n;
    logic [3:0] per;
    logic [3:0] lvl;
    logic [3:0] rnd;
    logic [7:0] tl;
  } vec_t;

  vec_t tbl[$];
  int runlen;
  int nlev;
  int guard;

  initial begin
    // per = {prelim, answer, post, levelChng}
    tbl.push_back('{1, 0, 1,  4'b1000, 0, 0, 2});
    tbl.push_back('{0, 1, 1,  4'b1000, 0, 0, 2});
    tbl.push_back('{0, 0, 6,  4'b1000, 0, 0, 1});
    tbl.push_back('{0, 0, 1,  4'b0100, 0, 0, 3});
    tbl.push_back('{1, 0, 1,  4'b0100, 0, 0, 3});
    tbl.push_back('{0, 0, 11, 4'b0010, 0, 0, 1});
    tbl.push_back('{0, 0, 4,  4'b1000, 0, 1, 2});
    tbl.push_back('{0, 0, 8,  4'b0100, 0, 1, 3});
    tbl.push_back('{0, 0, 4,  4'b0100, 0, 1, 2});
    tbl.push_back('{0, 1, 1,  4'b0010, 0, 1, 1});
    tbl.push_back('{0, 1, 3,  4'b0010, 0, 1, 1});
    tbl.push_back('{0, 0, 1,  4'b0001, 0, 0, 1});
    tbl.push_back('{0, 0, 3,  4'b0001, 0, 0, 1});
    tbl.push_back('{0, 0, 1,  4'b1000, 1, 0, 2});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    m_reset();
    cmp("reset_outs", 32'(d_vec()), 32'h0);
    reset = 1'b0;
    step("idle_hold");

    // Vector table: basic round, ignored inputs, early answer, level
    foreach (tbl[i]) begin
      start = tbl[i].st;
      answerDone = tbl[i].ad;
      for (int k = 0; k < tbl[i].n; k++) step("tbl_model");
      cmp($sformatf("tbl%0d_per", i),
          {prelimPeriod, answerPeriod, postPeriod, levelChng}, tbl[i].per);
      cmp($sformatf("tbl%0d_lvl", i), level, tbl[i].lvl);
      cmp($sformatf("tbl%0d_rnd", i), round, tbl[i].rnd);
      cmp($sformatf("tbl%0d_tl", i), ticksLeft, tbl[i].tl);
      cmp($sformatf("tbl%0d_busy", i), busy, 1);
    end

    // Full game to DONE
    runlen = 0; nlev = 0; guard = 0;
    while (!gameOver && guard < 300) begin
      step("game");
      guard++;
      if (levelChng) runlen++;
      else if (runlen != 0) begin
        nlev++;
        cmp("lvl_len", runlen, 4);
        runlen = 0;
      end
    end
    cmp("game_bound", guard < 300, 1);
    cmp("lvl_runs", nlev, 1);
    cmp("done_over", gameOver, 1);
    cmp("done_level", level, 1);
    cmp("done_busy", busy, 0);
    cmp("done_tl", ticksLeft, 0);
    repeat (3) step("done_hold");
    cmp("done_stay", gameOver, 1);
    start = 1'b1;
    step("restart");
    cmp("restart_pre", prelimPeriod, 1);
    cmp("restart_lvl", level, 0);
    cmp("restart_tl", ticksLeft, PT);

    // Coincident answerDone with ANSWER expiry
    guard = 0;
    while (!(m_ph == 2 && m_cyc == 1) && guard < 100) begin
      step("to_expiry");
      guard++;
    end
    cmp("coin_bound", guard < 100, 1);
    answerDone = 1'b1;
    step("coin");
    cmp("coin_post", {answerPeriod, postPeriod}, 2'b01);
    cmp("coin_tl", ticksLeft, OT);
    for (int k = 0; k < 3; k++) begin
      step("coin_hold");
      cmp("coin_hold_post", postPeriod, 1);
    end

    // Reset mid-POST at level 1
    guard = 0;
    while (!(m_ph == 3 && m_lvl == 1) && guard < 300) begin
      step("to_post_l1");
      guard++;
    end
    cmp("post_l1_bound", guard < 300, 1);
    cmp("post_l1_lvl", level, 1);
    reset = 1'b1;
    #2;
    m_reset();
    cmp("async_rst", 32'(d_vec()), 32'h0);
    step("rst_hold");
    reset = 1'b0;
    for (int k = 0; k < 5; k++) step("idle_after");
    cmp("idle_busy", busy, 0);

    // Randomised run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        #1;
        m_reset();
        check_model("rnd_async_rst");
        step("rnd_rst");
        reset = 1'b0;
      end else begin
        start = ($urandom_range(0, 29) == 0);
        answerDone = ($urandom_range(0, 7) == 0);
        step("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/period_sequencer.md
# period_sequencer

Round/level controller for the symbol-counting game. It drives the level-type `prelimPeriod`, `answerPeriod`, `postPeriod` and `levelChng` signals that the edge-blip stage turns into one-cycle strobes. Each round runs three timed periods: preliminary, answer and post. After a fixed number of rounds it performs a level change, and after the final level it stops in a game-over state.

## Interface
Parameters:
- `TICK_DIV`, 50000: clk cycles per timing tick; must be ≥2.
- `PRELIM_TICKS`, 20: ticks in the preliminary period; must be ≥1.
- `ANSWER_TICKS`, 50: ticks in the answer period; must be ≥1.
- `POST_TICKS`, 10: ticks in the post period; must be ≥1.
- `ROUNDS_PER_LEVEL`, 4: rounds before a level change; must be ≥1.
- `MAX_LEVEL`, 8: number of levels; game over after level MAX_LEVEL-1 completes.
- `TICK_W`, 8: width of `ticksLeft`; must hold the largest *_TICKS value.
- `LEVEL_W`, 4: width of `level` and `round`.

Ports:
- `clk`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: pulse that begins a game; honoured only in IDLE or DONE.
- `answerDone`, in, 1: pulse meaning the player submitted; ends ANSWER early.
- `prelimPeriod`, out, 1: high throughout PRELIM.
- `answerPeriod`, out, 1: high throughout ANSWER.
- `postPeriod`, out, 1: high throughout POST.
- `levelChng`, out, 1: high throughout LEVEL.
- `level`, out, LEVEL_W: current level, counting from 0.
- `round`, out, LEVEL_W: round within the level, 0..ROUNDS_PER_LEVEL-1.
- `ticksLeft`, out, TICK_W: ticks remaining in the current timed state; 0 in IDLE and DONE.
- `busy`, out, 1: high in every state except IDLE and DONE.
- `gameOver`, out, 1: high in DONE.

## Operation
- States: IDLE, PRELIM, ANSWER, POST, LEVEL, DONE. All outputs are registered and decoded from the state.
- Reset forces IDLE. All outputs go to 0, the prescaler goes to 0, and `level`/`round` go to 0.
- IDLE/DONE + `start` → PRELIM. Clear `level` and `round`, and load `ticksLeft` = PRELIM_TICKS.
- The prescaler counts 0..TICK_DIV-1 and issues a tick when it wraps. It clears to 0 on every state entry, so a timed state lasts exactly N×TICK_DIV cycles.
- `ticksLeft` loads N on entry and decrements on each tick. The tick that takes it from 1 to 0 exits the state.
- PRELIM expiry → ANSWER, loading ANSWER_TICKS.
- ANSWER expiry or `answerDone` → POST, loading POST_TICKS. If `answerDone` coincides with expiry, the result is a single transition to POST.
- POST expiry:
  - If `round` < ROUNDS_PER_LEVEL-1: increment `round`, go to PRELIM.
  - Otherwise: clear `round`, go to LEVEL, loading 1 tick.
- LEVEL expiry:
  - If `level` == MAX_LEVEL-1: go to DONE; `level` holds its value.
  - Otherwise: increment `level`, go to PRELIM.
- `start` outside IDLE/DONE is ignored. `answerDone` outside ANSWER is ignored.
- The four period outputs are mutually exclusive. Each one is low for at least one full state between assertions, so the downstream blip fires once per entry.

## Timing
- `start` sampled high at edge k: `prelimPeriod` and `busy` are high after edge k, and `ticksLeft` = PRELIM_TICKS.
- A timed state entered at edge e exits at edge e + N×TICK_DIV. The next state's output rises on that same edge, with no gap cycle.
- `answerDone` sampled at edge k in ANSWER: `postPeriod` is high after edge k.
- `level`/`round` update on the same edge as the state transition.
- Asserting `reset` asynchronously clears all outputs, including mid-period. After release, the block sits in IDLE until `start`.

## Structure
- Shared package `symcounter_pkg`: the state enum `seq_state_t` and default tick constants.
- Sub-module `tick_prescaler`: parameter TICK_DIV; inputs `clk`, `reset`, `clear`; output `tick`.
- The FSM, `ticksLeft` counter and `level`/`round` counters stay in `period_sequencer`.

## Test plan
All scenarios use TICK_DIV=4, PRELIM=2, ANSWER=3, POST=1, ROUNDS_PER_LEVEL=2, MAX_LEVEL=2.
- Basic round: `start` at edge 0 → PRELIM for edges 0–8, ANSWER from edge 8, POST from edge 20, PRELIM from edge 24 with `round`=1.
- Early answer: `answerDone` 5 cycles into ANSWER → `postPeriod` rises on the next edge; `ticksLeft`=1; POST lasts 4 cycles.
- Full game: 4 rounds and 2 LEVEL states → `levelChng` high 4 cycles each time, `level` goes 0→1, then DONE with `gameOver`=1 and `level`=1. `start` in DONE → PRELIM with `level`=0.
- Ignored inputs: `start` mid-ANSWER and `answerDone` during PRELIM/POST → no change in state or `ticksLeft`.
- Coincident exit: `answerDone` on the cycle ANSWER expires → exactly one POST entry with POST_TICKS.
- Reset mid-POST at level 1 → all outputs 0 immediately; after release, IDLE holds until `start`.
